inst_fetch_ctrl: RTL and testbench

- Fetch sequencer for the combinational instruction memory (32-bit PC in, 32-bit INST_CODE out, same-cycle read).
- Owns the PC register, steps it by 4 and registers each fetched word into a one-entry output stage with a valid/ready handshake to decode.
- Handles taken-branch redirect and stops fetching at the end of initialised memory.
- Sits between the instruction memory and the decode/register-file stage of the 64-bit core.

---
 rtl/inst_fetch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction fetch sequencer with one-entry output stage
//
// Purpose:
//   Owns the fetch PC, reads the combinational instruction memory and registers
//   each word into a one-entry valid/ready stage towards decode. Handles branch
//   redirects, flags misaligned redirect targets and halts at the end of the image.
//
// Ports:
//   CLK, RESET          clock; synchronous active-low reset
//   START               level, leaves IDLE when sampled high
//   PC / INST_CODE      fetch address out, same-cycle instruction word in
//   INST_OUT / INST_PC  registered instruction and its address
//   INST_VALID/READY    handshake to decode
//   REDIRECT/_PC        one-cycle branch/jump request and target
//   HALTED, FAULT       in HALT state; sticky misaligned-redirect flag
//   FETCH_COUNT,
//   STALL_COUNT         saturating perf counters, only with FETCH_PERF_EN defined
//
// Build option: FETCH_PERF_EN

module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] MEM_BYTES = 32'd32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  output logic [31:0] PC,
  input  logic [31:0] INST_CODE,
  output logic [31:0] INST_OUT,
  output logic [31:0] INST_PC,
  output logic        INST_VALID,
  input  logic        INST_READY,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        HALTED,
  output logic        FAULT
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] FETCH_COUNT,
  output logic [31:0] STALL_COUNT
`endif
);

  localparam logic [31:0] LAST_PC = MEM_BYTES - 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_valid;
  logic        r_fault;

  logic        w_misaligned;
  logic        w_in_range;
  logic        w_fetch_slot;
  logic        w_capture;
  logic        w_redirect_take;
  logic        w_stall;
  logic        w_halted;

  assign w_misaligned = (REDIRECT_PC[1:0] != 2'b00);
  assign w_in_range   = (r_pc <= LAST_PC);
  // Output stage can take a new word: empty, or being drained this cycle.
  assign w_fetch_slot = (!r_valid || INST_READY) && !REDIRECT;

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (REDIRECT && w_misaligned) begin
          w_next_state = ST_HALT;
        end else if (START) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        if (REDIRECT) begin
          if (w_misaligned) begin
            w_next_state = ST_HALT;
          end
        end else if (w_fetch_slot && !w_in_range) begin
          w_next_state = ST_HALT;
        end
      end
      ST_HALT: w_next_state = ST_HALT;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_halted        = (r_state == ST_HALT);
    w_redirect_take = REDIRECT && (r_state != ST_HALT);
    w_capture       = (r_state == ST_RUN) && w_fetch_slot && w_in_range;
    w_stall         = (r_state == ST_RUN) && r_valid && !INST_READY && !REDIRECT;
  end

  // Fetch datapath
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_pc      <= RESET_PC;
      r_inst    <= 32'd0;
      r_inst_pc <= 32'd0;
      r_valid   <= 1'b0;
      r_fault   <= 1'b0;
    end else if (w_redirect_take) begin
      // Flush: a same-cycle transfer has already been seen by decode.
      r_valid <= 1'b0;
      if (w_misaligned) begin
        r_fault <= 1'b1;
      end else begin
        r_pc <= REDIRECT_PC;
      end
    end else if (w_capture) begin
      r_inst    <= INST_CODE;
      r_inst_pc <= r_pc;
      r_valid   <= 1'b1;
      r_pc      <= r_pc + 32'd4;
    end else if ((r_state != ST_IDLE) && r_valid && INST_READY) begin
      // End of image in RUN, or draining in HALT: entry consumed, nothing refills it.
      r_valid <= 1'b0;
    end
  end

  assign PC         = r_pc;
  assign INST_OUT   = r_inst;
  assign INST_PC    = r_inst_pc;
  assign INST_VALID = r_valid;
  assign HALTED     = w_halted;
  assign FAULT      = r_fault;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_capture && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign FETCH_COUNT = r_fetch_cnt;
  assign STALL_COUNT = r_stall_cnt;
`else
  logic w_unused_stall;
  assign w_unused_stall = w_stall;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - directed self-checking bench for inst_fetch_ctrl

module tb_inst_fetch_ctrl;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [31:0] PC;
  logic [31:0] INST_CODE;
  logic [31:0] INST_OUT;
  logic [31:0] INST_PC;
  logic        INST_VALID;
  logic        INST_READY;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        HALTED;
  logic        FAULT;
`ifdef FETCH_PERF_EN
  logic [31:0] FETCH_COUNT;
  logic [31:0] STALL_COUNT;
`endif

  int n_cmp;
  int n_bad;

  logic [31:0] mem [8];

  inst_fetch_ctrl #(
    .RESET_PC (32'd0),
    .MEM_BYTES(32'd32)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .PC         (PC),
    .INST_CODE  (INST_CODE),
    .INST_OUT   (INST_OUT),
    .INST_PC    (INST_PC),
    .INST_VALID (INST_VALID),
    .INST_READY (INST_READY),
    .REDIRECT   (REDIRECT),
    .REDIRECT_PC(REDIRECT_PC),
    .HALTED     (HALTED),
    .FAULT      (FAULT)
`ifdef FETCH_PERF_EN
    ,
    .FETCH_COUNT(FETCH_COUNT),
    .STALL_COUNT(STALL_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory: combinational, 8 words, out-of-range reads return a marker.
  assign INST_CODE = (PC < 32'd32) ? mem[PC[4:2]] : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET       = 1'b0;
    START       = 1'b0;
    REDIRECT    = 1'b0;
    REDIRECT_PC = 32'd0;
    INST_READY  = 1'b0;
    tick();
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({PC, INST_OUT, INST_PC} !== {32'd0, 32'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL reset_regs: PC=%h INST_OUT=%h INST_PC=%h expected all 0", PC, INST_OUT, INST_PC);
    end
    n_cmp++;
    if ({INST_VALID, HALTED, FAULT} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: valid/halted/fault=%b expected 000", {INST_VALID, HALTED, FAULT});
    end
    INST_READY = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (PC !== 32'd0 || INST_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_fetch: PC=%h valid=%b expected 0/0", PC, INST_VALID);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    INST_READY = 1'b1;
    START      = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (INST_VALID !== 1'b1 || INST_PC !== 32'(4 * i) || INST_OUT !== mem[i] || PC !== 32'(4 * i + 4)) begin
        n_bad++;
        $display("FAIL seq_%0d: valid=%b INST_PC=%h INST_OUT=%h PC=%h expected 1/%h/%h/%h",
                 i, INST_VALID, INST_PC, INST_OUT, PC, 32'(4 * i), mem[i], 32'(4 * i + 4));
      end
      n_cmp++;
      if (HALTED !== 1'b0) begin
        n_bad++;
        $display("FAIL seq_halted_%0d: HALTED=%b expected 0", i, HALTED);
      end
    end
    tick();
    n_cmp++;
    if (HALTED !== 1'b1 || INST_VALID !== 1'b0 || PC !== 32'd32) begin
      n_bad++;
      $display("FAIL seq_end: HALTED=%b valid=%b PC=%h expected 1/0/00000020", HALTED, INST_VALID, PC);
    end
    START = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    INST_READY = 1'b1;
    START      = 1'b1;
    tick();
    tick();
    tick();
    tick();
    INST_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (INST_VALID !== 1'b1 || INST_PC !== 32'd8 || INST_OUT !== mem[2] || PC !== 32'd12) begin
        n_bad++;
        $display("FAIL stall_%0d: valid=%b INST_PC=%h INST_OUT=%h PC=%h expected 1/8/%h/c",
                 i, INST_VALID, INST_PC, INST_OUT, PC, mem[2]);
      end
    end
    INST_READY = 1'b1;
    tick();
    n_cmp++;
    if (INST_VALID !== 1'b1 || INST_PC !== 32'd12 || INST_OUT !== mem[3]) begin
      n_bad++;
      $display("FAIL stall_release: valid=%b INST_PC=%h INST_OUT=%h expected 1/c/%h", INST_VALID, INST_PC, INST_OUT, mem[3]);
    end
    START = 1'b0;
  endtask

  task automatic test_redirect();
    do_reset();
    INST_READY = 1'b1;
    START      = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (INST_PC !== 32'd16 || INST_VALID !== 1'b1) begin
      n_bad++;
      $display("FAIL redir_setup: INST_PC=%h valid=%b expected 10/1", INST_PC, INST_VALID);
    end
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'd4;
    tick();
    REDIRECT = 1'b0;
    n_cmp++;
    if (INST_VALID !== 1'b0 || PC !== 32'd4) begin
      n_bad++;
      $display("FAIL redir_flush: valid=%b PC=%h expected 0/4", INST_VALID, PC);
    end
    tick();
    n_cmp++;
    if (INST_VALID !== 1'b1 || INST_PC !== 32'd4 || INST_OUT !== mem[1]) begin
      n_bad++;
      $display("FAIL redir_first: valid=%b INST_PC=%h INST_OUT=%h expected 1/4/%h", INST_VALID, INST_PC, INST_OUT, mem[1]);
    end
    tick();
    n_cmp++;
    if (INST_VALID !== 1'b1 || INST_PC !== 32'd8 || INST_OUT !== mem[2]) begin
      n_bad++;
      $display("FAIL redir_second: valid=%b INST_PC=%h INST_OUT=%h expected 1/8/%h", INST_VALID, INST_PC, INST_OUT, mem[2]);
    end
    START = 1'b0;
  endtask

  task automatic test_idle_redirect_start();
    do_reset();
    INST_READY  = 1'b1;
    START       = 1'b1;
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'd12;
    tick();
    REDIRECT = 1'b0;
    n_cmp++;
    if (PC !== 32'd12 || INST_VALID !== 1'b0 || HALTED !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_redir: PC=%h valid=%b halted=%b expected c/0/0", PC, INST_VALID, HALTED);
    end
    tick();
    n_cmp++;
    if (INST_VALID !== 1'b1 || INST_PC !== 32'd12 || INST_OUT !== mem[3]) begin
      n_bad++;
      $display("FAIL idle_redir_run: valid=%b INST_PC=%h INST_OUT=%h expected 1/c/%h", INST_VALID, INST_PC, INST_OUT, mem[3]);
    end
    START = 1'b0;
  endtask

  task automatic test_fault();
    do_reset();
    INST_READY = 1'b1;
    START      = 1'b1;
    tick();
    tick();
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'd30;
    tick();
    REDIRECT = 1'b0;
    n_cmp++;
    if (FAULT !== 1'b1 || HALTED !== 1'b1 || PC !== 32'd4 || INST_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_entry: fault=%b halted=%b PC=%h valid=%b expected 1/1/4/0", FAULT, HALTED, PC, INST_VALID);
    end
    REDIRECT    = 1'b1;
    REDIRECT_PC = 32'd8;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (FAULT !== 1'b1 || HALTED !== 1'b1 || PC !== 32'd4 || INST_VALID !== 1'b0) begin
        n_bad++;
        $display("FAIL fault_hold_%0d: fault=%b halted=%b PC=%h valid=%b expected 1/1/4/0", i, FAULT, HALTED, PC, INST_VALID);
      end
    end
    do_reset();
    n_cmp++;
    if (FAULT !== 1'b0 || HALTED !== 1'b0 || PC !== 32'd0) begin
      n_bad++;
      $display("FAIL fault_clear: fault=%b halted=%b PC=%h expected 0/0/0", FAULT, HALTED, PC);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    INST_READY = 1'b1;
    START      = 1'b1;
    tick();
    tick();
    tick();
    tick();
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    START = 1'b0;
    n_cmp++;
    if (PC !== 32'd0 || INST_VALID !== 1'b0 || HALTED !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_reset: PC=%h valid=%b halted=%b expected 0/0/0", PC, INST_VALID, HALTED);
    end
    tick();
    tick();
    n_cmp++;
    if (PC !== 32'd0 || INST_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL midrun_idle: PC=%h valid=%b expected 0/0", PC, INST_VALID);
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    int budget;
    do_reset();
    n_cmp++;
    if (FETCH_COUNT !== 32'd0 || STALL_COUNT !== 32'd0) begin
      n_bad++;
      $display("FAIL perf_reset: fetch=%0d stall=%0d expected 0/0", FETCH_COUNT, STALL_COUNT);
    end
    INST_READY = 1'b1;
    START      = 1'b1;
    tick();
    tick();
    tick();
    INST_READY = 1'b0;
    tick();
    tick();
    tick();
    INST_READY = 1'b1;
    budget = 0;
    while (HALTED !== 1'b1 && budget < 40) begin
      tick();
      budget++;
    end
    n_cmp++;
    if (HALTED !== 1'b1) begin
      n_bad++;
      $display("FAIL perf_halt_timeout: halted=%b expected 1", HALTED);
    end
    n_cmp++;
    if (FETCH_COUNT !== 32'd8 || STALL_COUNT !== 32'd3) begin
      n_bad++;
      $display("FAIL perf_counts: fetch=%0d stall=%0d expected 8/3", FETCH_COUNT, STALL_COUNT);
    end
    START = 1'b0;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    mem[2] = 32'h0020_81B3;
    mem[3] = 32'h4011_0233;
    mem[4] = 32'h0041_F2B3;
    mem[5] = 32'h0041_E333;
    mem[6] = 32'h0033_03B3;
    mem[7] = 32'h0000_0073;
    RESET       = 1'b0;
    START       = 1'b0;
    INST_READY  = 1'b0;
    REDIRECT    = 1'b0;
    REDIRECT_PC = 32'd0;

    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_idle_redirect_start();
    test_fault();
    test_reset_mid_run();
`ifdef FETCH_PERF_EN
    test_perf();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
